// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART transceiver.
// Optional feature macro used elsewhere in this slice: UART_RX_FRAME_ERR_EN.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_e;

  // Bits needed to hold a count of 0 .. clks-1.
  function automatic int cnt_width(input int clks);
    return (clks > 2) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with synchronous clear.
// hit flags either the last clock of a bit or the half-bit point.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic half,
  output logic hit
);

  localparam int W = cnt_width(CLKS_PER_BIT);
  localparam logic [W-1:0] FULL_N = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF_N = W'((CLKS_PER_BIT - 1) / 2);

  logic [W-1:0] cnt_r;

  // Count clocks within the current bit; the owning FSM clears on hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + W'(1);
    end
  end

  assign hit = (cnt_r == (half ? HALF_N : FULL_N));

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent TX serialiser and RX deserialiser.
// Define UART_RX_FRAME_ERR_EN to add the o_rx_frame_err stop-bit check.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_dv,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_active,
  output logic       o_tx_serial,
  output logic       o_tx_done,
  input  logic       i_rx_serial,
  output logic       o_rx_dv,
  output logic [7:0] o_rx_byte
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       o_rx_frame_err
`endif
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e          tx_state_r;
  logic [DATA_BITS-1:0] tx_byte_r;
  logic [2:0]           tx_idx_r;
  logic                 tx_hit_s;
  logic                 tx_clr_s;

  uart_state_e          rx_state_r;
  logic [DATA_BITS-1:0] rx_shift_r;
  logic [2:0]           rx_idx_r;
  logic [1:0]           rx_sync_r;
  logic                 rx_bit_s;
  logic                 rx_hit_s;
  logic                 rx_clr_s;
  logic                 rx_half_s;

  assign tx_clr_s  = (tx_state_r == IDLE) || (tx_state_r == CLEANUP) || tx_hit_s;
  assign rx_clr_s  = (rx_state_r == IDLE) || (rx_state_r == CLEANUP) || rx_hit_s;
  assign rx_half_s = (rx_state_r == START);
  assign rx_bit_s  = rx_sync_r[1];

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk(i_clk), .rst_n(i_rst_n), .clr(tx_clr_s), .half(1'b0), .hit(tx_hit_s)
  );

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk(i_clk), .rst_n(i_rst_n), .clr(rx_clr_s), .half(rx_half_s), .hit(rx_hit_s)
  );

  // TX FSM: the line is driven one bit ahead so each bit starts on the state edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_state_r  <= IDLE;
      tx_byte_r   <= '0;
      tx_idx_r    <= 3'd0;
      o_tx_serial <= 1'b1;
      o_tx_active <= 1'b0;
      o_tx_done   <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      case (tx_state_r)
        IDLE: begin
          o_tx_serial <= 1'b1;
          if (i_tx_dv) begin
            tx_byte_r   <= i_tx_byte;
            o_tx_active <= 1'b1;
            o_tx_serial <= 1'b0;
            tx_state_r  <= START;
          end
        end
        START: begin
          if (tx_hit_s) begin
            tx_idx_r    <= 3'd0;
            o_tx_serial <= tx_byte_r[0];
            tx_state_r  <= DATA;
          end
        end
        DATA: begin
          if (tx_hit_s) begin
            if (tx_idx_r == LAST_BIT) begin
              tx_idx_r    <= 3'd0;
              o_tx_serial <= 1'b1;
              tx_state_r  <= STOP;
            end else begin
              tx_idx_r    <= tx_idx_r + 3'd1;
              o_tx_serial <= tx_byte_r[tx_idx_r + 3'd1];
            end
          end
        end
        STOP: begin
          if (tx_hit_s) begin
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b1;
            tx_state_r  <= CLEANUP;
          end
        end
        CLEANUP: tx_state_r <= IDLE;
        default: begin
          o_tx_serial <= 1'b1;
          o_tx_active <= 1'b0;
          tx_state_r  <= IDLE;
        end
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous RX pin; idles high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_sync_r <= 2'b11;
    end else begin
      rx_sync_r <= {rx_sync_r[0], i_rx_serial};
    end
  end

  // RX FSM: confirm the start bit at mid-bit, then sample every bit centre.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_state_r     <= IDLE;
      rx_shift_r     <= '0;
      rx_idx_r       <= 3'd0;
      o_rx_byte      <= 8'h00;
      o_rx_dv        <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      o_rx_frame_err <= 1'b0;
`endif
    end else begin
      o_rx_dv        <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      o_rx_frame_err <= 1'b0;
`endif
      case (rx_state_r)
        IDLE: begin
          if (!rx_bit_s) begin
            rx_state_r <= START;
          end
        end
        START: begin
          if (rx_hit_s) begin
            rx_idx_r   <= 3'd0;
            rx_state_r <= rx_bit_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (rx_hit_s) begin
            rx_shift_r <= {rx_bit_s, rx_shift_r[DATA_BITS-1:1]};
            if (rx_idx_r == LAST_BIT) begin
              rx_idx_r   <= 3'd0;
              rx_state_r <= STOP;
            end else begin
              rx_idx_r <= rx_idx_r + 3'd1;
            end
          end
        end
        STOP: begin
          if (rx_hit_s) begin
`ifdef UART_RX_FRAME_ERR_EN
            if (rx_bit_s) begin
              o_rx_byte <= rx_shift_r;
              o_rx_dv   <= 1'b1;
            end else begin
              o_rx_frame_err <= 1'b1;
            end
`else
            o_rx_byte <= rx_shift_r;
            o_rx_dv   <= 1'b1;
`endif
            rx_state_r <= CLEANUP;
          end
        end
        CLEANUP: rx_state_r <= IDLE;
        default: rx_state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Scoreboard bench for uart_transceiver: loopback and directly driven RX frames.
module tb_uart_transceiver;
  import uart_pkg::*;

  localparam int C = 434;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_active, tx_serial, tx_done, rx_dv;
  logic [7:0] rx_byte;
  logic       loop_en = 1'b1;
  logic       rx_drv = 1'b1;
  logic       rx_line;
`ifdef UART_RX_FRAME_ERR_EN
  logic       rx_frame_err;
`endif

  assign rx_line = loop_en ? tx_serial : rx_drv;

  uart_transceiver #(.CLKS_PER_BIT(C)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_tx_dv(tx_dv), .i_tx_byte(tx_byte),
    .o_tx_active(tx_active), .o_tx_serial(tx_serial), .o_tx_done(tx_done),
    .i_rx_serial(rx_line), .o_rx_dv(rx_dv), .o_rx_byte(rx_byte)
`ifdef UART_RX_FRAME_ERR_EN
    , .o_rx_frame_err(rx_frame_err)
`endif
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int tx_t0 = 0;
  int last_done_cyc = 0;
  int done_cnt = 0;
  int rx_cnt = 0;
  int ferr_cnt = 0;
  int exp_ferr = 0;
  logic [7:0] ferr_keep = 8'h00;
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_done_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pop expectations whenever the DUT presents a pulse.
  initial forever begin
    logic [7:0] e;
    @(negedge clk);
    if (rst_n) begin
      if (rx_dv === 1'b1) begin
        rx_cnt++;
        if (exp_rx_q.size() == 0) check("rx_dv_unexpected", rx_dv, 0);
        else begin
          e = exp_rx_q.pop_front();
          check("rx_byte", rx_byte, e);
        end
      end
      if (tx_done === 1'b1) begin
        done_cnt++;
        last_done_cyc = cyc;
        if (exp_done_q.size() == 0) check("tx_done_unexpected", tx_done, 0);
        else begin
          e = exp_done_q.pop_front();
          check("rx_byte_at_done", rx_byte, e);
          check("rx_pending_at_done", exp_rx_q.size(), 0);
        end
      end
`ifdef UART_RX_FRAME_ERR_EN
      if (rx_frame_err === 1'b1) begin
        ferr_cnt++;
        if (exp_ferr == 0) check("frame_err_unexpected", rx_frame_err, 0);
        else begin
          exp_ferr--;
          check("rx_byte_kept_on_err", rx_byte, ferr_keep);
        end
      end
`endif
    end
  end

  task automatic send_tx(input logic [7:0] b, input bit expect_it);
    @(negedge clk);
    tx_byte = b;
    tx_dv = 1'b1;
    tx_t0 = cyc + 1;
    if (expect_it) begin
      exp_rx_q.push_back(b);
      exp_done_q.push_back(b);
    end
    @(negedge clk);
    tx_dv = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int k = 0;
    while (done_cnt < target && k < 12 * C) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check(name, done_cnt, target);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (C) @(negedge clk);
    end
    rx_drv = stop;
    if (stop) repeat (C) @(negedge clk);
    else repeat (3 * C / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (C) @(negedge clk);
  endtask

  initial begin
    logic [9:0] seq_3f;
    int d0;
    int r0;
    seq_3f = 10'b1001111110;

    repeat (3) @(negedge clk);
    check("rst_tx_serial", tx_serial, 1);
    check("rst_tx_active", tx_active, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_rx_dv", rx_dv, 0);
    check("rst_rx_byte", rx_byte, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback 0xAB and frame length
    send_tx(8'hAB, 1'b1);
    check("tx_active_busy", tx_active, 1);
    wait_done(1, "done_ab");
    check("frame_len", last_done_cyc - tx_t0, 10 * C);
    check("tx_active_after", tx_active, 0);

    // 0x3F ten microseconds later, with line waveform at bit centres
    repeat (500) @(negedge clk);
    send_tx(8'h3F, 1'b1);
    repeat (C / 2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tx_bit_%0d", k), tx_serial, seq_3f[k]);
      repeat (C) @(negedge clk);
    end
    wait_done(2, "done_3f");
    check("rx_byte_3f", rx_byte, 8'h3F);

    // Second request mid-frame is dropped
    repeat (20) @(negedge clk);
    send_tx(8'h96, 1'b1);
    repeat (2000) @(negedge clk);
    tx_byte = 8'h55;
    tx_dv = 1'b1;
    @(negedge clk);
    tx_dv = 1'b0;
    wait_done(3, "done_96");
    repeat (2 * C) @(negedge clk);
    check("single_done", done_cnt, 3);
    check("rx_byte_96", rx_byte, 8'h96);

    // Short low glitch on an idle RX line, then a real 0x00 frame
    loop_en = 1'b0;
    r0 = rx_cnt;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (100) @(negedge clk);
    rx_drv = 1'b1;
    repeat (600) @(negedge clk);
    check("glitch_rx_idle", dut.rx_state_r, IDLE);
    check("glitch_no_dv", rx_cnt, r0);
    exp_rx_q.push_back(8'h00);
    send_rx(8'h00, 1'b1);
    check("rx_00_count", rx_cnt, r0 + 1);
    check("rx_byte_00", rx_byte, 8'h00);

    // Reset during TX data bits
    loop_en = 1'b1;
    repeat (10) @(negedge clk);
    send_tx(8'hE7, 1'b0);
    repeat (3 * C) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tx_serial", tx_serial, 1);
    check("midrst_tx_active", tx_active, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    r0 = rx_cnt;
    repeat (11 * C) @(negedge clk);
    check("midrst_no_done", done_cnt, d0);
    check("midrst_no_rx", rx_cnt, r0);
    send_tx(8'hC3, 1'b1);
    wait_done(d0 + 1, "done_c3");
    check("rx_byte_c3", rx_byte, 8'hC3);

`ifdef UART_RX_FRAME_ERR_EN
    // Stop bit held low: error pulse, byte unchanged
    loop_en = 1'b0;
    r0 = rx_cnt;
    ferr_keep = 8'hC3;
    exp_ferr = 1;
    send_rx(8'hA5, 1'b0);
    repeat (C) @(negedge clk);
    check("ferr_count", ferr_cnt, 1);
    check("ferr_no_dv", rx_cnt, r0);
    check("ferr_byte_kept", rx_byte, 8'hC3);
`endif

    check("exp_rx_drained", exp_rx_q.size(), 0);
    check("exp_done_drained", exp_done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
